dcache_ctrl: RTL and testbench

Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache controller. It terminates the MemoryAccess stage's 66-bit D-cache request bus and returns the 33-bit {miss, data} response. Misses and all stores are sequenced to a backing memory through a req/ack handshake. While miss=1 the pipeline holds the request stable.

---
 rtl/dcache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, one-word-per-line, write-through,
// no-write-allocate data cache controller with a req/ack backing memory port.
module dcache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [65:0] Dcache_bus_in,
  output logic [32:0] Dcache_bus_out,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic        flush_pend;
  logic        fwd_valid;
  logic [31:0] fwd_data;

  // Request bus fields.
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_en;
  logic             req_rw;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             unused_addr_lsb;

  assign req_addr        = Dcache_bus_in[65:34];
  assign req_wdata       = Dcache_bus_in[33:2];
  assign req_en          = Dcache_bus_in[1];
  assign req_rw          = Dcache_bus_in[0];
  assign req_idx         = req_addr[IDX_W+1:2];
  assign req_tag         = req_addr[31:IDX_W+2];
  assign lat_idx         = mem_addr[IDX_W+1:2];
  assign lat_tag         = mem_addr[31:IDX_W+2];
  assign unused_addr_lsb = ^req_addr[1:0];

  // Lookups: live request, latched transaction, and the just-filled word.
  logic req_hit, lat_hit, fwd_hit;
  assign req_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign lat_hit = valid[lat_idx] && (tag_arr[lat_idx] == lat_tag);
  // A fill that was flushed on arrival is still returned to its requester once.
  assign fwd_hit = fwd_valid && (req_addr[31:2] == mem_addr[31:2]);

  logic        miss_c;
  logic [31:0] rdata_c;
  logic        start_rd, start_wr;

  // Next-state and combinational response.
  always_comb begin
    state_nx = state;
    miss_c   = 1'b0;
    rdata_c  = '0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    case (state)
      IDLE: begin
        if (req_en) begin
          if (req_rw) begin
            miss_c   = 1'b1;
            start_wr = 1'b1;
            state_nx = WR_WAIT;
          end else if (fwd_hit) begin
            rdata_c = fwd_data;
          end else if (req_hit) begin
            rdata_c = data_arr[req_idx];
          end else begin
            miss_c   = 1'b1;
            start_rd = 1'b1;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        miss_c = 1'b1;
        if (mem_ack) state_nx = IDLE;
      end
      WR_WAIT: begin
        miss_c = 1'b1;
        if (mem_ack) state_nx = WR_DONE;
      end
      WR_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic fill_done, store_done, enter_idle, flush_now;
  assign fill_done  = (state == RD_WAIT) && mem_ack;
  assign store_done = (state == WR_WAIT) && mem_ack;
  assign enter_idle = (state != IDLE) && (state_nx == IDLE);
  assign flush_now  = ((state == IDLE) && flush) || (enter_idle && (flush || flush_pend));

  assign Dcache_bus_out = Rst ? 33'd0 : {miss_c, rdata_c};

  // State, memory port, valid bits and pending-flush bookkeeping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      flush_pend <= 1'b0;
      fwd_valid  <= 1'b0;
      fwd_data   <= '0;
      valid      <= '0;
    end else begin
      state     <= state_nx;
      fwd_valid <= fill_done;
      if (fill_done) fwd_data <= mem_rdata;

      if (start_rd || start_wr) begin
        mem_req  <= 1'b1;
        mem_we   <= start_wr;
        mem_addr <= {req_addr[31:2], 2'b00};
        if (start_wr) mem_wdata <= req_wdata;
      end else if (fill_done || store_done) begin
        mem_req <= 1'b0;
      end

      if (flush_now) flush_pend <= 1'b0;
      else if (flush && (state != IDLE)) flush_pend <= 1'b1;

      if (flush_now) valid <= '0;
      else if (fill_done) valid[lat_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: refill on read ack, write-update on store ack to a resident line.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (fill_done) begin
        tag_arr[lat_idx]  <= lat_tag;
        data_arr[lat_idx] <= mem_rdata;
      end else if (store_done && lat_hit) begin
        data_arr[lat_idx] <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
module tb_dcache_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [65:0] bus_in = '0;
  logic [31:0] mem_rdata = '0;
  logic [32:0] bus_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  dcache_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Dcache_bus_in(bus_in), .Dcache_bus_out(bus_out),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          miss_cycles;
    bit          chk_rdata;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    bit          chk_wdata;
    logic [31:0] wdata;
  } mtx_t;

  rsp_t rsp_q[$];
  mtx_t mtx_q[$];
  bit   mon_en = 1'b0;
  int   miss_run = 0;

  // Response scoreboard: count miss cycles, pop an expectation on completion.
  always @(negedge Clk) begin
    rsp_t e;
    if (mon_en) begin
      if (bus_out[32]) miss_run++;
      else begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: completion rdata=%h with nothing expected", bus_out[31:0]);
        end else begin
          e = rsp_q.pop_front();
          if (miss_run != e.miss_cycles) begin
            errors++;
            $display("FAIL rsp_miss_cycles: got %0d required %0d", miss_run, e.miss_cycles);
          end
          if (e.chk_rdata) begin
            checks++;
            if (bus_out[31:0] !== e.rdata) begin
              errors++;
              $display("FAIL rsp_rdata: got %h required %h", bus_out[31:0], e.rdata);
            end
          end
        end
        miss_run = 0;
      end
    end else begin
      miss_run = 0;
    end
  end

  logic        prev_req = 1'b0;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;

  // Memory-port scoreboard: pop on each new request, then hold-stable checks.
  always @(negedge Clk) begin
    mtx_t m;
    if (mem_req && !prev_req) begin
      checks++;
      if (mtx_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: we=%b addr=%h wdata=%h with nothing expected", mem_we, mem_addr, mem_wdata);
      end else begin
        m = mtx_q.pop_front();
        if (mem_we !== m.we || mem_addr !== m.addr) begin
          errors++;
          $display("FAIL mem_cmd: got we=%b addr=%h required we=%b addr=%h", mem_we, mem_addr, m.we, m.addr);
        end
        if (m.chk_wdata) begin
          checks++;
          if (mem_wdata !== m.wdata) begin
            errors++;
            $display("FAIL mem_wdata: got %h required %h", mem_wdata, m.wdata);
          end
        end
      end
      cur_we = mem_we; cur_addr = mem_addr; cur_wdata = mem_wdata;
    end else if (mem_req) begin
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {cur_we, cur_addr, cur_wdata}) begin
        errors++;
        $display("FAIL mem_stable: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                 mem_we, mem_addr, mem_wdata, cur_we, cur_addr, cur_wdata);
      end
    end
    prev_req = mem_req;
  end

  // Present one request until miss=0, acking the memory after ack_after held cycles.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_after, input logic [31:0] fill, input int flush_at,
                        output int reqs);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    reqs = 0;
    bus_in = {a, wd, 1'b1, we};
    mon_en = 1'b1;
    while (!done && cyc < 200) begin
      mem_ack = 1'b0;
      flush   = 1'b0;
      if (mem_req) begin
        if (reqs == flush_at) flush = 1'b1;
        if (reqs == ack_after) begin
          mem_ack   = 1'b1;
          mem_rdata = fill;
        end
        reqs++;
      end
      @(negedge Clk);
      if (!bus_out[32]) done = 1'b1;
      @(posedge Clk); #1;
      cyc++;
    end
    mem_ack   = 1'b0;
    flush     = 1'b0;
    bus_in[1] = 1'b0;
    mon_en    = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: addr=%h still missing after %0d cycles", a, cyc);
    end
  endtask

  task automatic exp_rsp(input int mc, input bit chk, input logic [31:0] rd);
    rsp_q.push_back('{mc, chk, rd});
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input bit chk, input logic [31:0] wd);
    mtx_q.push_back('{we, a, chk, wd});
  endtask

  task automatic test_reset();
    bus_in = {32'h0000_0040, 32'h0, 2'b10};
    @(negedge Clk);
    checks++;
    if (bus_out !== 33'd0) begin errors++; $display("FAIL reset_bus_out: got %h required 0", bus_out); end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mem_port: got req=%b we=%b addr=%h wdata=%h required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    bus_in = '0;
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus_out !== 33'd0) begin errors++; $display("FAIL idle_disabled: got %h required 0", bus_out); end
    @(posedge Clk); #1;
  endtask

  task automatic test_read_fill();
    int r;
    exp_mem(1'b0, 32'h0000_0040, 1'b0, 32'h0);
    exp_rsp(5, 1'b1, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, -1, r);
    checks++;
    if (r != 4) begin errors++; $display("FAIL fill_req_cycles: got %0d required 4", r); end
    exp_rsp(0, 1'b1, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0042, 32'h0, 0, 32'h0, -1, r);
    checks++;
    if (r != 0) begin errors++; $display("FAIL rehit_no_req: got %0d required 0", r); end
  endtask

  task automatic test_write_hit();
    int r;
    exp_mem(1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678);
    exp_rsp(3, 1'b0, 32'h0);
    access(1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'h0, -1, r);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL no_dup_store: got mem_req=%b required 0", mem_req); end
    end
    @(posedge Clk); #1;
    exp_rsp(0, 1'b1, 32'h1234_5678);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, -1, r);
    checks++;
    if (r != 0) begin errors++; $display("FAIL write_update_no_req: got %0d required 0", r); end
  endtask

  task automatic test_write_miss();
    int r;
    exp_mem(1'b1, 32'h0000_0400, 1'b1, 32'hCAFE_F00D);
    exp_rsp(2, 1'b0, 32'h0);
    access(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 0, 32'h0, -1, r);
    exp_rsp(0, 1'b1, 32'h1234_5678);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, -1, r);
    exp_mem(1'b0, 32'h0000_0400, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h0BAD_C0DE);
    access(1'b0, 32'h0000_0400, 32'h0, 0, 32'h0BAD_C0DE, -1, r);
    checks++;
    if (r != 1) begin errors++; $display("FAIL no_allocate: got %0d req cycles required 1", r); end
  endtask

  task automatic test_conflict();
    int r;
    exp_mem(1'b0, 32'h0000_0040, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h1111_1111);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h1111_1111, -1, r);
    exp_mem(1'b0, 32'h0000_0080, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h2222_2222);
    access(1'b0, 32'h0000_0083, 32'h0, 0, 32'h2222_2222, -1, r);
    exp_rsp(0, 1'b1, 32'h2222_2222);
    access(1'b0, 32'h0000_0080, 32'h0, 0, 32'h0, -1, r);
    exp_mem(1'b0, 32'h0000_0040, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h3333_3333);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h3333_3333, -1, r);
    checks++;
    if (r != 1) begin errors++; $display("FAIL conflict_refill: got %0d req cycles required 1", r); end
  endtask

  task automatic test_flush_rd_wait();
    int r;
    exp_mem(1'b0, 32'h0000_0044, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h4444_4444);
    access(1'b0, 32'h0000_0044, 32'h0, 0, 32'h4444_4444, -1, r);
    exp_mem(1'b0, 32'h0000_0048, 1'b0, 32'h0);
    exp_rsp(4, 1'b1, 32'h5555_5555);
    access(1'b0, 32'h0000_0048, 32'h0, 2, 32'h5555_5555, 1, r);
    exp_mem(1'b0, 32'h0000_0048, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h5A5A_5A5A);
    access(1'b0, 32'h0000_0048, 32'h0, 0, 32'h5A5A_5A5A, -1, r);
    checks++;
    if (r != 1) begin errors++; $display("FAIL flush_fill_dropped: got %0d req cycles required 1", r); end
    exp_mem(1'b0, 32'h0000_0040, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h0F0F_0F0F);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0F0F_0F0F, -1, r);
  endtask

  task automatic test_rst_wr_wait();
    int r;
    exp_mem(1'b0, 32'h0000_0044, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h4444_4444);
    access(1'b0, 32'h0000_0044, 32'h0, 0, 32'h4444_4444, -1, r);
    exp_rsp(0, 1'b1, 32'h0F0F_0F0F);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, -1, r);
    exp_mem(1'b1, 32'h0000_0040, 1'b1, 32'h7777_7777);
    bus_in = {32'h0000_0040, 32'h7777_7777, 2'b11};
    @(posedge Clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL wr_wait_entry: got req=%b we=%b required 1 1", mem_req, mem_we);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus_out !== 33'd0) begin errors++; $display("FAIL rst_bus_out: got %h required 0", bus_out); end
    @(posedge Clk); #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_abandon: got req=%b addr=%h required 0 0", mem_req, mem_addr);
    end
    Rst       = 1'b0;
    bus_in    = '0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_9999;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    @(negedge Clk);
    checks++;
    if (mem_req !== 1'b0 || bus_out !== 33'd0) begin
      errors++; $display("FAIL late_ack: got req=%b out=%h required 0 0", mem_req, bus_out);
    end
    @(posedge Clk); #1;
    exp_mem(1'b0, 32'h0000_0040, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'h8888_8888);
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h8888_8888, -1, r);
    exp_mem(1'b0, 32'h0000_0044, 1'b0, 32'h0);
    exp_rsp(2, 1'b1, 32'hABCD_0123);
    access(1'b0, 32'h0000_0044, 32'h0, 0, 32'hABCD_0123, -1, r);
    checks++;
    if (r != 1) begin errors++; $display("FAIL rst_invalidate: got %0d req cycles required 1", r); end
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_flush_rd_wait();
    test_rst_wr_wait();
    repeat (2) @(posedge Clk);
    checks++;
    if (rsp_q.size() != 0) begin errors++; $display("FAIL rsp_leftover: got %0d required 0", rsp_q.size()); end
    checks++;
    if (mtx_q.size() != 0) begin errors++; $display("FAIL mem_leftover: got %0d required 0", mtx_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
